// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data accesses.
// Define ARB_STARVE_GUARD_EN to bound how long a pending fetch can be starved by data traffic.
module mem_port_arbiter #(
  parameter int unsigned WAIT_MAX   = 255,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,

  output logic        pc_write,
  output logic        pipe_stall,
  output logic        timeout
);

  localparam int unsigned WaitW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              timeout_q, timeout_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic              grant_data, grant_fetch, fetch_first;

  // Grant decision; no grant in an ack cycle because the requester still shows the finished
  // request on its lines.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state_q == StIdle && !if_ack_q && !dm_ack_q) begin
      if (dm_req && !fetch_first) begin
        grant_data = 1'b1;
      end else if (if_req) begin
        grant_fetch = 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIM + 1);

  logic [StarveW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_fetch) begin
      starve_d = '0;
    end else if (grant_data && starve_q != StarveW'(STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign fetch_first = if_req && (starve_q >= StarveW'(STARVE_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_lim;
  assign unused_starve_lim = ^STARVE_LIM;
  assign fetch_first       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    timeout_d  = 1'b0;
    wait_d     = wait_q;

    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d = StData;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          wait_d  = '0;
        end else if (grant_fetch) begin
          state_d = StFetch;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wait_d  = '0;
        end
      end
      StFetch, StData: begin
        if (mem_ready) begin
          state_d = StIdle;
          if (state_q == StFetch) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end else if (wait_q == WaitW'(WAIT_MAX - 1)) begin
          // Memory never answered: abort with zero data so the requester can move on.
          state_d   = StIdle;
          timeout_d = 1'b1;
          if (state_q == StFetch) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      timeout_q  <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      timeout_q  <= timeout_d;
      wait_q     <= wait_d;
    end
  end

  assign mem_req    = (state_q != StIdle);
  assign mem_we     = (state_q == StData) & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign if_rdata   = if_rdata_q;
  assign if_ack     = if_ack_q;
  assign dm_rdata   = dm_rdata_q;
  assign dm_ack     = dm_ack_q;
  assign timeout    = timeout_q;

  assign pc_write   = ~(if_req & ~if_ack_q);
  assign pipe_stall = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic against a memory model,
// plus directed latency, priority, timeout, reset and starvation scenarios.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, pc_write, pipe_stall, timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pipe_stall(pipe_stall),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        to;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        if_q[$];
  exp_t        dm_q[$];
  exp_t        mon_e;
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] dm_last;
  int          mem_mode;   // 0: ready at once, 1: random delay, 2: never ready
  int          mem_wait = 0;
  int          cur_delay = 0;
  logic        mon_en, log_en;
  logic        prev_req = 1'b0, prev_we = 1'b0, lg_prev = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic        grant_log[$];
  logic        exp_pc, exp_ps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] fmem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fmem(a);
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : fmem(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: answers mem_req after a mode-dependent delay and checks request stability.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      mem_ready = 1'b0;
      mem_wait  = 0;
      prev_req  = 1'b0;
    end else begin
      if (mem_req && prev_req) begin
        check("mem_addr_stable", mem_addr, prev_addr);
        check("mem_wdata_stable", mem_wdata, prev_wdata);
        check("mem_we_stable", {31'b0, mem_we}, {31'b0, prev_we});
      end
      if (mem_req && mem_addr >= 32'h4000) check("fetch_mem_we", {31'b0, mem_we}, 32'h0);
      prev_req   = mem_req;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
      mem_ready  = 1'b0;
      mem_rdata  = $urandom;
      if (mem_req && mem_mode != 2) begin
        if (mem_wait >= ((mem_mode == 1) ? cur_delay : 0)) begin
          mem_ready = 1'b1;
          mem_rdata = slave_read(mem_addr);
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          mem_wait  = 0;
          cur_delay = $urandom_range(0, 4);
        end else begin
          mem_wait++;
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and checks the combinational handshakes.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (if_ack) begin
        if (if_q.size() == 0) begin
          fail_now("if_ack_unexpected");
        end else begin
          mon_e = if_q.pop_front();
          check("if_rdata", if_rdata, mon_e.data);
          check("if_timeout", {31'b0, timeout}, {31'b0, mon_e.to});
        end
      end
      if (dm_ack) begin
        if (dm_q.size() == 0) begin
          fail_now("dm_ack_unexpected");
        end else begin
          mon_e = dm_q.pop_front();
          check("dm_rdata", dm_rdata, mon_e.data);
          check("dm_timeout", {31'b0, timeout}, {31'b0, mon_e.to});
        end
      end
      if (timeout && !if_ack && !dm_ack) fail_now("timeout_without_ack");
      exp_pc = ~(if_req & ~if_ack);
      exp_ps = dm_req & ~dm_ack;
      check("pc_write", {31'b0, pc_write}, {31'b0, exp_pc});
      check("pipe_stall", {31'b0, pipe_stall}, {31'b0, exp_ps});
    end
  end

  // Grant log: 1 = fetch grant (fetch addresses live at 0x4000 and above), 0 = data grant.
  always @(negedge clk) begin
    if (log_en && mem_req && !lg_prev) grant_log.push_back(mem_addr >= 32'h4000);
    lg_prev = mem_req;
  end

  task automatic do_fetch(input logic [31:0] a);
    int cnt;
    cnt     = 0;
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back('{data: ref_read(a), to: 1'b0});
    do begin
      tick();
      cnt++;
    end while (!if_ack && cnt < 3000);
    if (!if_ack) fail_now("fetch_ack_wait");
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic hold);
    int cnt;
    cnt      = 0;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dm_req   = 1'b1;
    if (we) ref_mem[a] = wd;
    else dm_last = ref_read(a);
    dm_q.push_back('{data: dm_last, to: 1'b0});
    do begin
      tick();
      cnt++;
    end while (!dm_ack && cnt < 3000);
    if (!dm_ack) fail_now("data_ack_wait");
    if (!hold || !dm_ack) dm_req = 1'b0;
  endtask

  task automatic fetch_master(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      repeat ($urandom_range(0, 3)) tick();
      a = 32'h4000 + ($urandom_range(0, 1023) << 2);
      do_fetch(a);
    end
  endtask

  task automatic data_master(input int n);
    for (int i = 0; i < n; i++) begin
      logic        we;
      logic [31:0] a;
      repeat ($urandom_range(0, 3)) tick();
      we = ($urandom_range(0, 1) == 1);
      a  = 32'h100 + ($urandom_range(0, 15) << 2);
      do_data(we, a, $urandom, 1'b0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int first;
    int exp_first;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_mode = 0; mon_en = 1'b0; log_en = 1'b0; dm_last = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_if_ack", {31'b0, if_ack}, 32'h0);
    check("rst_dm_ack", {31'b0, dm_ack}, 32'h0);
    check("rst_timeout", {31'b0, timeout}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_pc_write", {31'b0, pc_write}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(); tick();

    // Single fetch at minimum latency.
    mem_arr[32'h10] = 32'h8C01_0004;
    if_addr = 32'h10; if_req = 1'b1;
    if_q.push_back('{data: 32'h8C01_0004, to: 1'b0});
    #1;
    check("f_pc_write_low", {31'b0, pc_write}, 32'h0);
    tick();
    check("f_mem_req", {31'b0, mem_req}, 32'h1);
    check("f_mem_we", {31'b0, mem_we}, 32'h0);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_no_ack_yet", {31'b0, if_ack}, 32'h0);
    tick();
    check("f_ack", {31'b0, if_ack}, 32'h1);
    check("f_rdata", if_rdata, 32'h8C01_0004);
    check("f_mem_req_off", {31'b0, mem_req}, 32'h0);
    if_req = 1'b0;
    tick();
    check("f_ack_pulse", {31'b0, if_ack}, 32'h0);
    repeat (2) tick();

    // Simultaneous store and fetch: data wins, fetch follows.
    if_addr = 32'h40; if_req = 1'b1;
    dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    ref_mem[32'h20] = 32'hDEAD_BEEF;
    dm_q.push_back('{data: dm_last, to: 1'b0});
    if_q.push_back('{data: ref_read(32'h40), to: 1'b0});
    tick();
    check("p_mem_we", {31'b0, mem_we}, 32'h1);
    check("p_mem_addr", mem_addr, 32'h20);
    check("p_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("p_stall", {31'b0, pipe_stall}, 32'h1);
    tick();
    check("p_dm_ack", {31'b0, dm_ack}, 32'h1);
    check("p_stall_drop", {31'b0, pipe_stall}, 32'h0);
    check("p_if_waiting", {31'b0, if_ack}, 32'h0);
    dm_req = 1'b0;
    cnt = 0;
    while (!mem_req && cnt < 10) begin
      tick();
      cnt++;
    end
    check("p_fetch_grant", {31'b0, mem_req}, 32'h1);
    check("p_fetch_we", {31'b0, mem_we}, 32'h0);
    check("p_fetch_addr", mem_addr, 32'h40);
    cnt = 0;
    while (!if_ack && cnt < 10) begin
      tick();
      cnt++;
    end
    check("p_fetch_ack", {31'b0, if_ack}, 32'h1);
    if_req = 1'b0;
    repeat (2) tick();

    // Random concurrent traffic.
    mem_mode = 1;
    fork
      fetch_master(30);
      data_master(40);
    join
    repeat (4) tick();

    // Load that never gets mem_ready.
    mem_mode = 2;
    dm_we = 1'b0; dm_addr = 32'h24; dm_req = 1'b1;
    dm_last = '0;
    dm_q.push_back('{data: 32'h0, to: 1'b1});
    tick();
    check("t_mem_req", {31'b0, mem_req}, 32'h1);
    repeat (254) tick();
    check("t_still_waiting", {31'b0, mem_req}, 32'h1);
    check("t_no_early_ack", {31'b0, dm_ack}, 32'h0);
    tick();
    check("t_dm_ack", {31'b0, dm_ack}, 32'h1);
    check("t_timeout", {31'b0, timeout}, 32'h1);
    check("t_dm_rdata", dm_rdata, 32'h0);
    check("t_mem_req_off", {31'b0, mem_req}, 32'h0);
    dm_req = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a data transfer.
    dm_we = 1'b0; dm_addr = 32'h28; dm_req = 1'b1;
    tick();
    check("r_mem_req_before", {31'b0, mem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("r_mem_req_async", {31'b0, mem_req}, 32'h0);
    check("r_mem_we", {31'b0, mem_we}, 32'h0);
    check("r_dm_ack", {31'b0, dm_ack}, 32'h0);
    check("r_if_rdata", if_rdata, 32'h0);
    check("r_mem_addr", mem_addr, 32'h0);
    dm_req = 1'b0;
    mem_mode = 0;
    dm_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("r_no_ack_after", {31'b0, dm_ack}, 32'h0);
    check("r_idle_after", {31'b0, mem_req}, 32'h0);
    do_data(1'b0, 32'h20, 32'h0, 1'b0);
    check("r_load_after_reset", dm_rdata, 32'hDEAD_BEEF);
    repeat (3) tick();

    // Data requests held back-to-back while a fetch waits.
    grant_log.delete();
    log_en = 1'b1;
    fork
      do_fetch(32'h4100);
      begin
        for (int i = 0; i < 12; i++) do_data(1'b0, 32'h100 + i * 4, 32'h0, 1'b1);
        dm_req = 1'b0;
      end
    join
    repeat (3) tick();
    log_en = 1'b0;
    first = grant_log.size();
    for (int i = grant_log.size() - 1; i >= 0; i--) begin
      if (grant_log[i]) first = i;
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_first = 4;
`else
    exp_first = 12;
`endif
    check("s_first_fetch_pos", first, exp_first);
    check("s_total_grants", grant_log.size(), 13);

    repeat (3) tick();
    check("q_if_drained", if_q.size(), 0);
    check("q_dm_drained", dm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
